// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI voice allocator.
// Holds the status nibble codes, the parser state type and the note event record.
package midi_pkg;

    localparam logic [3:0] MIDI_NOTE_OFF   = 4'h8;
    localparam logic [3:0] MIDI_NOTE_ON    = 4'h9;
    localparam logic [3:0] MIDI_PROG_CHG   = 4'hC;
    localparam logic [3:0] MIDI_CHAN_PRESS = 4'hD;
    localparam logic [7:0] MIDI_SYS_RT     = 8'hF8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA1 = 2'd1,
        ST_DATA2 = 2'd2
    } parse_state_t;

    typedef struct packed {
        logic       valid;
        logic       on;
        logic [6:0] note;
        logic [6:0] velocity;
    } note_event_t;

endpackage

// File: rtl/midi_parser.sv
// Channel-voice message parser with running status.
// Emits a registered single-entry note event for note-on/off on the selected channel.
module midi_parser
    import midi_pkg::*;
#(
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_midi_byte,
    output note_event_t o_event
);

    parse_state_t r_state;
    parse_state_t w_state_nxt;
    logic [7:0]   r_status;
    logic [7:0]   w_status_nxt;
    logic         r_status_valid;
    logic         w_status_valid_nxt;
    logic [6:0]   r_data1;
    logic [6:0]   w_data1_nxt;
    note_event_t  r_event;
    note_event_t  w_event_nxt;
    logic         w_one_byte;
    logic         w_is_note;

    assign w_one_byte = (r_status[7:4] == MIDI_PROG_CHG) || (r_status[7:4] == MIDI_CHAN_PRESS);
    assign w_is_note  = (r_status[3:0] == CHANNEL) &&
                        ((r_status[7:4] == MIDI_NOTE_ON) || (r_status[7:4] == MIDI_NOTE_OFF));
    assign o_event    = r_event;

    // Parser state, running status and event register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_status       <= 8'h00;
            r_status_valid <= 1'b0;
            r_data1        <= 7'd0;
            r_event        <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_status       <= w_status_nxt;
            r_status_valid <= w_status_valid_nxt;
            r_data1        <= w_data1_nxt;
            r_event        <= w_event_nxt;
        end
    end

    // Next-state decode for each received byte.
    always_comb begin
        w_state_nxt        = r_state;
        w_status_nxt       = r_status;
        w_status_valid_nxt = r_status_valid;
        w_data1_nxt        = r_data1;
        w_event_nxt        = '0;
        if (i_byte_valid) begin
            if (i_midi_byte[7]) begin
                if (i_midi_byte >= MIDI_SYS_RT) begin
                    // Real-time bytes pass through without touching the message in progress.
                    w_state_nxt = r_state;
                end else if (i_midi_byte[7:4] == 4'hF) begin
                    w_status_valid_nxt = 1'b0;
                    w_state_nxt        = ST_IDLE;
                end else begin
                    w_status_nxt       = i_midi_byte;
                    w_status_valid_nxt = 1'b1;
                    w_state_nxt        = ST_DATA1;
                end
            end else begin
                case (r_state)
                    ST_IDLE, ST_DATA1: begin
                        if (!r_status_valid) begin
                            w_state_nxt = ST_IDLE;
                        end else if (w_one_byte) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_data1_nxt = i_midi_byte[6:0];
                            w_state_nxt = ST_DATA2;
                        end
                    end
                    ST_DATA2: begin
                        w_state_nxt = ST_IDLE;
                        if (w_is_note) begin
                            w_event_nxt.valid    = 1'b1;
                            w_event_nxt.on       = (r_status[7:4] == MIDI_NOTE_ON) &&
                                                   (i_midi_byte[6:0] != 7'd0);
                            w_event_nxt.note     = r_data1;
                            w_event_nxt.velocity = i_midi_byte[6:0];
                        end else begin
                            w_event_nxt = '0;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end
        end else begin
            w_state_nxt = r_state;
        end
    end

endmodule

// File: rtl/midi_voice_allocator.sv
// MIDI voice allocator: parses the byte stream and assigns note events to a voice pool.
// Owns retrigger, free-voice allocation, round-robin stealing and release.
module midi_voice_allocator
    import midi_pkg::*;
#(
    parameter int         NUM_VOICES = 4,
    parameter logic [3:0] CHANNEL    = 4'd0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    byte_valid,
    input  logic [7:0]              midi_byte,
    output logic [NUM_VOICES-1:0]   voice_active,
    output logic [7*NUM_VOICES-1:0] voice_note,
    output logic [7*NUM_VOICES-1:0] voice_velocity,
    output logic [NUM_VOICES-1:0]   voice_update
);

    localparam int PW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    note_event_t           w_event;
    logic [NUM_VOICES-1:0] r_active;
    logic [NUM_VOICES-1:0] w_active_nxt;
    logic [6:0]            r_note [NUM_VOICES];
    logic [6:0]            w_note_nxt [NUM_VOICES];
    logic [6:0]            r_vel [NUM_VOICES];
    logic [6:0]            w_vel_nxt [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_update;
    logic [NUM_VOICES-1:0] w_update_nxt;
    logic [PW-1:0]         r_ptr;
    logic [PW-1:0]         w_ptr_nxt;
    logic                  w_match_hit;
    logic [PW-1:0]         w_match_idx;
    logic                  w_free_hit;
    logic [PW-1:0]         w_free_idx;

    midi_parser #(.CHANNEL(CHANNEL)) u_parser (
        .clock        (clock),
        .reset        (reset),
        .i_byte_valid (byte_valid),
        .i_midi_byte  (midi_byte),
        .o_event      (w_event)
    );

    assign voice_active = r_active;
    assign voice_update = r_update;

    genvar g;
    generate
        for (g = 0; g < NUM_VOICES; g++) begin : g_pack
            assign voice_note[7*g +: 7]     = r_note[g];
            assign voice_velocity[7*g +: 7] = r_vel[g];
        end
    endgenerate

    // Lowest-index priority encoders for a sounding match and a free slot.
    always_comb begin
        w_match_hit = 1'b0;
        w_match_idx = '0;
        w_free_hit  = 1'b0;
        w_free_idx  = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (r_active[v] && (r_note[v] == w_event.note)) begin
                w_match_hit = 1'b1;
                w_match_idx = PW'(v);
            end else begin
                w_match_hit = w_match_hit;
            end
            if (!r_active[v]) begin
                w_free_hit = 1'b1;
                w_free_idx = PW'(v);
            end else begin
                w_free_hit = w_free_hit;
            end
        end
    end

    // Voice table update for the pending event.
    always_comb begin
        w_active_nxt = r_active;
        w_note_nxt   = r_note;
        w_vel_nxt    = r_vel;
        w_ptr_nxt    = r_ptr;
        w_update_nxt = '0;
        if (w_event.valid && w_event.on) begin
            if (w_match_hit) begin
                w_vel_nxt[w_match_idx]    = w_event.velocity;
                w_update_nxt[w_match_idx] = 1'b1;
            end else if (w_free_hit) begin
                w_active_nxt[w_free_idx] = 1'b1;
                w_note_nxt[w_free_idx]   = w_event.note;
                w_vel_nxt[w_free_idx]    = w_event.velocity;
                w_update_nxt[w_free_idx] = 1'b1;
            end else begin
                w_active_nxt[r_ptr] = 1'b1;
                w_note_nxt[r_ptr]   = w_event.note;
                w_vel_nxt[r_ptr]    = w_event.velocity;
                w_update_nxt[r_ptr] = 1'b1;
                w_ptr_nxt = (r_ptr == PW'(NUM_VOICES - 1)) ? PW'(0) : r_ptr + PW'(1);
            end
        end else if (w_event.valid) begin
            // Release keeps note and velocity so the envelope still knows the pitch.
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (r_active[v] && (r_note[v] == w_event.note)) begin
                    w_active_nxt[v] = 1'b0;
                    w_update_nxt[v] = 1'b1;
                end else begin
                    w_update_nxt[v] = 1'b0;
                end
            end
        end else begin
            w_update_nxt = '0;
        end
    end

    // Voice table, strobe and steal pointer registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_active <= '0;
            r_update <= '0;
            r_ptr    <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_note[v] <= 7'd0;
                r_vel[v]  <= 7'd0;
            end
        end else begin
            r_active <= w_active_nxt;
            r_update <= w_update_nxt;
            r_ptr    <= w_ptr_nxt;
            r_note   <= w_note_nxt;
            r_vel    <= w_vel_nxt;
        end
    end

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Self-checking bench for midi_voice_allocator: directed test-plan steps plus
// randomized byte streams compared against a message-level reference model.
module tb_midi_voice_allocator;

    localparam int NV = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic            byte_valid;
    logic [7:0]      midi_byte;
    logic [NV-1:0]   voice_active;
    logic [7*NV-1:0] voice_note;
    logic [7*NV-1:0] voice_velocity;
    logic [NV-1:0]   voice_update;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            run_st;
    int            dq[$];
    bit            m_act [NV];
    int            m_note [NV];
    int            m_vel [NV];
    int            m_ptr;
    logic [NV-1:0] m_upd;

    always #5 clock = ~clock;

    midi_voice_allocator #(.NUM_VOICES(NV), .CHANNEL(4'd0)) dut (
        .clock          (clock),
        .reset          (reset),
        .byte_valid     (byte_valid),
        .midi_byte      (midi_byte),
        .voice_active   (voice_active),
        .voice_note     (voice_note),
        .voice_velocity (voice_velocity),
        .voice_update   (voice_update)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        run_st = -1;
        dq.delete();
        m_ptr = 0;
        m_upd = '0;
        for (int i = 0; i < NV; i++) begin
            m_act[i] = 1'b0; m_note[i] = 0; m_vel[i] = 0;
        end
    endtask

    task automatic model_event(input bit on, input int n, input int v);
        int idx;
        idx = -1;
        if (on) begin
            for (int i = 0; i < NV; i++) if (idx < 0 && m_act[i] && m_note[i] == n) idx = i;
            if (idx >= 0) begin
                m_vel[idx] = v; m_upd[idx] = 1'b1;
            end else begin
                for (int i = 0; i < NV; i++) if (idx < 0 && !m_act[i]) idx = i;
                if (idx < 0) begin
                    idx = m_ptr;
                    m_ptr = (m_ptr + 1) % NV;
                end
                m_act[idx] = 1'b1; m_note[idx] = n; m_vel[idx] = v; m_upd[idx] = 1'b1;
            end
        end else begin
            for (int i = 0; i < NV; i++) begin
                if (m_act[i] && m_note[i] == n) begin
                    m_act[i] = 1'b0; m_upd[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        int hi;
        int need;
        m_upd = '0;
        if (b >= 8'hF8) return;
        if (b >= 8'hF0) begin run_st = -1; dq.delete(); return; end
        if (b >= 8'h80) begin run_st = b; dq.delete(); return; end
        if (run_st < 0) return;
        dq.push_back(int'(b));
        hi   = run_st / 16;
        need = (hi == 12 || hi == 13) ? 1 : 2;
        if (dq.size() == need) begin
            if ((hi == 8 || hi == 9) && (run_st % 16) == 0)
                model_event(hi == 9 && dq[1] != 0, dq[0], dq[1]);
            dq.delete();
        end
    endtask

    function automatic logic [63:0] exp_act();
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < NV; i++) r[i] = m_act[i];
        return r;
    endfunction

    function automatic logic [63:0] exp_note();
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < NV; i++) r[7*i +: 7] = m_note[i][6:0];
        return r;
    endfunction

    function automatic logic [63:0] exp_vel();
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < NV; i++) r[7*i +: 7] = m_vel[i][6:0];
        return r;
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_active"}, 64'(voice_active), exp_act());
        check({tag, "_note"}, 64'(voice_note), exp_note());
        check({tag, "_vel"}, 64'(voice_velocity), exp_vel());
    endtask

    // One byte, then check outputs two edges later and that the strobe drops after one cycle.
    task automatic send_byte(input logic [7:0] b);
        model_byte(b);
        @(negedge clock);
        byte_valid = 1'b1;
        midi_byte  = b;
        @(negedge clock);
        byte_valid = 1'b0;
        @(negedge clock);
        check_state("step");
        check("step_update", 64'(voice_update), 64'(m_upd));
        @(negedge clock);
        check("strobe_1cyc", 64'(voice_update), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        @(negedge clock);
        check_state("reset");
        check("reset_update", 64'(voice_update), 64'd0);
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] other [7];
        logic [7:0] b;
        int         r;
        other = '{8'h91, 8'hC0, 8'hD0, 8'hB0, 8'hF0, 8'hF8, 8'hE0};
        reset      = 1'b1;
        byte_valid = 1'b0;
        midi_byte  = 8'h00;
        model_reset();
        repeat (2) @(negedge clock);
        check_state("por");
        check("por_update", 64'(voice_update), 64'd0);
        reset = 1'b0;

        // Basic note-on
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        check("tp1_note0", 64'(voice_note[6:0]), 64'd60);
        check("tp1_vel0", 64'(voice_velocity[6:0]), 64'd100);

        // Running status, then note-off via velocity 0
        send_byte(8'h40); send_byte(8'h50);
        check("rs_note1", 64'(voice_note[13:7]), 64'd64);
        send_byte(8'h3C); send_byte(8'h00);
        check("rs_off_active", 64'(voice_active), 64'b0010);
        check("rs_off_held", 64'(voice_note[6:0]), 64'd60);

        // Pool full and stealing
        do_reset();
        send_byte(8'h90);
        for (int n = 60; n < 64; n++) begin send_byte(8'(n)); send_byte(8'h40); end
        send_byte(8'd70); send_byte(8'h41);
        check("steal0", 64'(voice_note[6:0]), 64'd70);
        send_byte(8'd71); send_byte(8'h42);
        check("steal1", 64'(voice_note[13:7]), 64'd71);
        send_byte(8'd71); send_byte(8'h22);
        check("retrig_vel", 64'(voice_velocity[13:7]), 64'h22);

        // Real-time insertion and aborted message
        do_reset();
        send_byte(8'h90); send_byte(8'hF8); send_byte(8'h3C); send_byte(8'hFE); send_byte(8'h64);
        check("rt_note0", 64'(voice_note[6:0]), 64'd60);
        do_reset();
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h80); send_byte(8'h3C); send_byte(8'h00);
        check("abort_active", 64'(voice_active), 64'd0);

        // Filtering
        send_byte(8'h91); send_byte(8'h3C); send_byte(8'h64);
        send_byte(8'hC0); send_byte(8'h05);
        send_byte(8'hF0); send_byte(8'h3C); send_byte(8'h64);
        check("filter_active", 64'(voice_active), 64'd0);

        // Reset between data bytes
        do_reset();
        send_byte(8'h90); send_byte(8'h3C);
        do_reset();
        send_byte(8'h64);
        check("rst_mid_active", 64'(voice_active), 64'd0);

        // Randomized stream, one byte at a time
        do_reset();
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      b = 8'h90;
            else if (r == 1) b = 8'h80;
            else if (r == 2) b = other[$urandom_range(0, 6)];
            else if (r <= 5) b = 8'(60 + $urandom_range(0, 6));
            else             b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 127));
            send_byte(b);
        end

        // Back-to-back burst with final state compare
        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      b = 8'h90;
            else if (r == 1) b = 8'h80;
            else if (r == 2) b = other[$urandom_range(0, 6)];
            else             b = ($urandom_range(0, 1) == 0) ? 8'(60 + $urandom_range(0, 6))
                                                            : 8'($urandom_range(0, 127));
            @(negedge clock);
            byte_valid = 1'b1;
            midi_byte  = b;
            model_byte(b);
        end
        @(negedge clock);
        byte_valid = 1'b0;
        repeat (3) @(negedge clock);
        check_state("burst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
